rc_adder_error_sweep: RTL and testbench

Exhaustive error-characterization controller for a WIDTH-bit approximate ripple-carry adder under test. It drives every operand pair (2^(2·WIDTH) combinations) into an external adder, samples the adder's WIDTH+1-bit sum, and compares it against an internal exact sum. It accumulates the error metrics used in delay/MAE trade-off studies: error count, maximum absolute error, sum of absolute errors and mean absolute error. It sits between the test harness (start/abort/done handshake) and one combinational approximate adder instance.

---
 rtl/rc_adder_error_sweep.sv | 205 ++++++++++++++++++++
 tb/tb_rc_adder_error_sweep.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rc_adder_error_sweep.sv
// rc_adder_error_sweep
// Exhaustive error-characterisation controller for an external WIDTH-bit
// approximate ripple-carry adder. Walks every operand pair, compares the
// adder's answer against an exact sum and accumulates error count,
// maximum absolute error, sum of absolute errors and mean absolute error.
// Two-stage pipeline: stage 1 captures exact/approx, stage 2 accumulates.

module rc_adder_error_sweep #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  output logic [WIDTH-1:0]     op_a,
  output logic [WIDTH-1:0]     op_b,
  input  logic [WIDTH:0]       approx_sum,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH:0]     err_count,
  output logic [WIDTH:0]       max_err,
  output logic [3*WIDTH+1:0]   sum_abs_err,
  output logic [WIDTH+1:0]     mae
);

  localparam int CW = 2 * WIDTH;  // counter width: one bit per operand bit
  localparam int SW = 3 * WIDTH + 2;  // accumulator width, overflow-free

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_n;
  logic [CW-1:0]     cnt_r;
  logic              busy_r;
  logic              done_r;
  logic              done_n;
  logic              cnt_clr_s;
  logic              cnt_inc_s;
  logic              cap_en_s;

  // Stage 1 registers
  logic              v1_r;
  logic [WIDTH:0]    exact_r;
  logic [WIDTH:0]    approx_r;

  // Stage 2 accumulators
  logic [CW:0]       err_r;
  logic [WIDTH:0]    max_r;
  logic [SW-1:0]     sum_r;
  logic [WIDTH+1:0]  mae_r;

  // Stage 2 combinational update values
  logic [WIDTH:0]    diff_s;
  logic [SW-1:0]     sum_next_s;
  logic [CW:0]       err_next_s;
  logic [WIDTH:0]    max_next_s;

  // Operands come straight from the registered counter so the adder sees
  // glitch-free inputs for a whole cycle.
  assign op_a        = cnt_r[WIDTH-1:0];
  assign op_b        = cnt_r[CW-1:WIDTH];
  assign busy        = busy_r;
  assign done        = done_r;
  assign err_count   = err_r;
  assign max_err     = max_r;
  assign sum_abs_err = sum_r;
  assign mae         = mae_r;

  // Next-state and control decode; start beats abort in IDLE, abort wins elsewhere.
  always_comb begin
    state_n   = state_r;
    done_n    = 1'b0;
    cnt_clr_s = 1'b0;
    cnt_inc_s = 1'b0;
    cap_en_s  = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_n   = S_RUN;
          cnt_clr_s = 1'b1;
        end else begin
          state_n   = S_IDLE;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_n = S_IDLE;
        end else begin
          cap_en_s = 1'b1;
          // Hold the counter on the last pair instead of wrapping.
          if (&cnt_r) begin
            state_n = S_DRAIN;
          end else begin
            cnt_inc_s = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (abort) begin
          state_n = S_IDLE;
        end else if (!v1_r) begin
          // Stage 2 has consumed the final sample; results are complete.
          state_n = S_IDLE;
          done_n  = 1'b1;
        end else begin
          state_n = S_DRAIN;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // State register with registered busy/done flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      busy_r  <= (state_n != S_IDLE);
      done_r  <= done_n;
    end
  end

  // Operand-pair counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (cnt_clr_s) begin
      cnt_r <= '0;
    end else if (cnt_inc_s) begin
      cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Stage 1: capture the exact reference and the adder's answer for the current pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_r     <= 1'b0;
      exact_r  <= '0;
      approx_r <= '0;
    end else begin
      v1_r <= cap_en_s;
      if (cap_en_s) begin
        exact_r  <= {1'b0, cnt_r[WIDTH-1:0]} + {1'b0, cnt_r[CW-1:WIDTH]};
        approx_r <= approx_sum;
      end else begin
        exact_r  <= exact_r;
        approx_r <= approx_r;
      end
    end
  end

  // Stage 2 datapath: absolute error and candidate accumulator values.
  always_comb begin
    diff_s = '0;
    if (approx_r >= exact_r) begin
      diff_s = approx_r - exact_r;
    end else begin
      diff_s = exact_r - approx_r;
    end
    sum_next_s = sum_r + {{(SW-WIDTH-1){1'b0}}, diff_s};
    err_next_s = err_r + {{CW{1'b0}}, (diff_s != '0)};
    if (diff_s > max_r) begin
      max_next_s = diff_s;
    end else begin
      max_next_s = max_r;
    end
  end

  // Stage 2 accumulators; a new sweep clears them, otherwise they hold between sweeps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r <= '0;
      max_r <= '0;
      sum_r <= '0;
      mae_r <= '0;
    end else if (cnt_clr_s) begin
      err_r <= '0;
      max_r <= '0;
      sum_r <= '0;
      mae_r <= '0;
    end else if (v1_r) begin
      err_r <= err_next_s;
      max_r <= max_next_s;
      sum_r <= sum_next_s;
      mae_r <= sum_next_s[SW-1:CW];
    end else begin
      err_r <= err_r;
      max_r <= max_r;
      sum_r <= sum_r;
      mae_r <= mae_r;
    end
  end

endmodule

// File: tb/tb_rc_adder_error_sweep.sv
// Bench for rc_adder_error_sweep: a WIDTH=2 instance for the functional
// scenarios and a WIDTH=6 instance for the exact-adder and mid-sweep
// reset scenarios. Expected sweep results are queued at start and popped
// when done pulses.

module tb_rc_adder_error_sweep;

  typedef struct {
    int     lat;
    longint err;
    longint mx;
    longint sm;
    longint mae;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // WIDTH=2 instance signals
  logic        rst_n, start, abort;
  logic [1:0]  op_a2, op_b2;
  logic [2:0]  approx2, exact2;
  logic        busy2, done2;
  logic [4:0]  err2;
  logic [2:0]  max2;
  logic [7:0]  sum2;
  logic [3:0]  mae2;

  // WIDTH=6 instance signals
  logic        rst_n_b, start_b, abort_b;
  logic [5:0]  op_a6, op_b6;
  logic [6:0]  approx6, exact6;
  logic        busy6, done6;
  logic [12:0] err6;
  logic [6:0]  max6;
  logic [19:0] sum6;
  logic [7:0]  mae6;

  int mode2, mode6;  // 0 exact, 1 bit0 cleared, 2 constant zero
  int n_checks = 0;
  int n_fail   = 0;
  int t0_2, t0_6;
  exp_t q2[$];
  exp_t q6[$];

  rc_adder_error_sweep #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .op_a(op_a2), .op_b(op_b2), .approx_sum(approx2),
    .busy(busy2), .done(done2), .err_count(err2), .max_err(max2),
    .sum_abs_err(sum2), .mae(mae2)
  );

  rc_adder_error_sweep #(.WIDTH(6)) dut6 (
    .clk(clk), .rst_n(rst_n_b), .start(start_b), .abort(abort_b),
    .op_a(op_a6), .op_b(op_b6), .approx_sum(approx6),
    .busy(busy6), .done(done6), .err_count(err6), .max_err(max6),
    .sum_abs_err(sum6), .mae(mae6)
  );

  // Behavioural approximate adders
  always_comb begin
    exact2 = {1'b0, op_a2} + {1'b0, op_b2};
    exact6 = {1'b0, op_a6} + {1'b0, op_b6};
    case (mode2)
      1:       approx2 = exact2 & 3'b110;
      2:       approx2 = 3'd0;
      default: approx2 = exact2;
    endcase
    case (mode6)
      1:       approx6 = exact6 & 7'b1111110;
      2:       approx6 = 7'd0;
      default: approx6 = exact6;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int sel, input bit push, input int lat,
                          input longint e_err, input longint e_max,
                          input longint e_sum, input longint e_mae);
    exp_t e;
    e.lat = lat; e.err = e_err; e.mx = e_max; e.sm = e_sum; e.mae = e_mae;
    if (sel == 0) begin
      if (push) q2.push_back(e);
      start = 1'b1;
      tick();
      start = 1'b0;
      t0_2 = cyc;
    end else begin
      if (push) q6.push_back(e);
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      t0_6 = cyc;
    end
  endtask

  task automatic wait_done(input int sel, input string tag);
    exp_t e;
    bit   found = 1'b0;
    int   k = 0;
    if ((sel == 0 && q2.size() == 0) || (sel != 0 && q6.size() == 0)) begin
      check({tag, "_sb_empty"}, 64'd1, 64'd0);
      return;
    end
    e = (sel == 0) ? q2.pop_front() : q6.pop_front();
    while (!found && k < 6000) begin
      tick();
      k++;
      found = (sel == 0) ? done2 : done6;
    end
    check({tag, "_done_seen"}, {63'd0, found}, 64'd1);
    if (found) begin
      check({tag, "_latency"}, cyc - ((sel == 0) ? t0_2 : t0_6), e.lat);
      check({tag, "_busy_low"}, (sel == 0) ? busy2 : busy6, 64'd0);
      check({tag, "_err_count"}, (sel == 0) ? err2 : err6, e.err);
      check({tag, "_max_err"}, (sel == 0) ? max2 : max6, e.mx);
      check({tag, "_sum_abs_err"}, (sel == 0) ? sum2 : sum6, e.sm);
      check({tag, "_mae"}, (sel == 0) ? mae2 : mae6, e.mae);
      tick();
      check({tag, "_done_one_cycle"}, (sel == 0) ? done2 : done6, 64'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0; rst_n_b = 1'b0;
    start = 1'b0; abort = 1'b0; start_b = 1'b0; abort_b = 1'b0;
    mode2 = 0; mode6 = 0;
    tick();
    tick();
    // Reset state
    check("rst_op_a", op_a2, 0);
    check("rst_op_b", op_b2, 0);
    check("rst_busy", busy2, 0);
    check("rst_done", done2, 0);
    check("rst_err", err2, 0);
    check("rst_max", max2, 0);
    check("rst_sum", sum2, 0);
    check("rst_mae", mae2, 0);
    check("rst_busy6", busy6, 0);
    rst_n = 1'b1; rst_n_b = 1'b1;
    tick();

    // Bit 0 cleared, WIDTH=2
    mode2 = 1;
    do_start(0, 1'b1, 18, 8, 1, 8, 0);
    check("lsb_busy", busy2, 1);
    check("lsb_pair0_a", op_a2, 0);
    check("lsb_pair0_b", op_b2, 0);
    tick();
    check("lsb_pair1_a", op_a2, 1);
    wait_done(0, "lsb");

    // Constant zero, WIDTH=2
    mode2 = 2;
    do_start(0, 1'b1, 18, 15, 6, 48, 3);
    wait_done(0, "zero");

    // Abort at T0+5
    do_start(0, 1'b0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) tick();
    check("abort_pair5_a", op_a2, 1);
    check("abort_pair5_b", op_b2, 1);
    check("abort_partial_err", err2, 3);
    check("abort_partial_sum", sum2, 6);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", busy2, 0);
    check("abort_no_done", done2, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("abort_idle_done", done2, 0);
      check("abort_frozen_a", op_a2, 1);
      check("abort_frozen_b", op_b2, 1);
    end
    do_start(0, 1'b1, 18, 15, 6, 48, 3);
    check("rerun_err_clr", err2, 0);
    check("rerun_sum_clr", sum2, 0);
    wait_done(0, "rerun");

    // start during RUN is ignored
    do_start(0, 1'b1, 18, 15, 6, 48, 3);
    for (int i = 0; i < 3; i++) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("runstart_a", op_a2, 0);
    check("runstart_b", op_b2, 1);
    check("runstart_busy", busy2, 1);
    wait_done(0, "runstart");

    // start together with abort in IDLE: start wins
    abort = 1'b1;
    do_start(0, 1'b1, 18, 15, 6, 48, 3);
    abort = 1'b0;
    check("startabort_busy", busy2, 1);
    wait_done(0, "startabort");

    // WIDTH=6: reset in the middle of a sweep
    mode6 = 1;
    do_start(1, 1'b0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 1000; i++) tick();
    check("mid_err_nonzero", {63'd0, (err6 != 13'd0)}, 64'd1);
    check("mid_busy", busy6, 1);
    rst_n_b = 1'b0;
    #1;
    check("async_op_a", op_a6, 0);
    check("async_op_b", op_b6, 0);
    check("async_busy", busy6, 0);
    check("async_done", done6, 0);
    check("async_err", err6, 0);
    check("async_max", max6, 0);
    check("async_sum", sum6, 0);
    check("async_mae", mae6, 0);
    tick();
    rst_n_b = 1'b1;
    tick();
    mode6 = 0;
    do_start(1, 1'b1, 4098, 0, 0, 0, 0);
    wait_done(1, "exact6");
    mode6 = 1;
    do_start(1, 1'b1, 4098, 2048, 1, 2048, 0);
    wait_done(1, "lsb6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
